// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU fetch/decode front end.
// Pure declarations; no logic.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CB_FETCH = 2'd1,
    ISR      = 2'd2,
    HALT     = 2'd3
  } fetch_state_t;

  localparam logic [7:0] OPCODE_NOP      = 8'h00;
  localparam logic [7:0] OPCODE_CB       = 8'hCB;
  localparam logic [7:0] INT_VECTOR_BASE = 8'h40;
  localparam int         INT_NUM         = 5;

endpackage

// File: rtl/gb_cpu_int_prio.sv
// Lowest-index-wins interrupt priority encoder.
// Purely combinational, zero latency; no backpressure.
module gb_cpu_int_prio #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_any,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  always_comb begin
    o_any    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any    = 1'b1;
        o_idx    = IW'(i);
        o_onehot = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_cpu_fetch_ctrl.sv
// Fetch controller: opcode latch, CB-prefix sequencing, IME/EI delay, HALT/HALT-bug and interrupt dispatch.
// Registered outputs update on the clk edge of an m_tick; pc_inc is combinational; no backpressure, m_tick paces all state.
module gb_cpu_fetch_ctrl
  import gb_cpu_common_pkg::*;
#(
  parameter int         NUM_INT       = INT_NUM,
  parameter logic [7:0] VECTOR_BASE   = INT_VECTOR_BASE,
  parameter int         VECTOR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_tick,
  input  logic [7:0]         fetch_data,
  input  logic               instr_last,
  input  logic               ctl_ei,
  input  logic               ctl_di,
  input  logic               ctl_reti,
  input  logic               ctl_halt,
  input  logic [NUM_INT-1:0] int_enable,
  input  logic [NUM_INT-1:0] int_flag,
  output logic [7:0]         opcode,
  output logic               cb_prefix,
  output logic               isr_cmd,
  output logic               pc_inc,
  output logic [NUM_INT-1:0] int_ack,
  output logic [7:0]         isr_vector,
  output logic               ime,
  output logic               halted
);

  localparam int IW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  localparam logic [1:0] ST_RUN      = 2'(RUN);
  localparam logic [1:0] ST_CB_FETCH = 2'(CB_FETCH);
  localparam logic [1:0] ST_ISR      = 2'(ISR);
  localparam logic [1:0] ST_HALT     = 2'(HALT);

  logic [1:0]         r_state;
  logic [7:0]         r_opcode;
  logic               r_cb_prefix;
  logic               r_isr_cmd;
  logic [NUM_INT-1:0] r_int_ack;
  logic [7:0]         r_isr_vector;
  logic               r_ime;
  logic               r_halted;
  logic               r_ei_pend;
  logic               r_halt_bug;

  logic               w_any;
  logic [IW-1:0]      w_idx;
  logic [NUM_INT-1:0] w_onehot;
  logic [7:0]         w_vector;
  logic               w_ime_upd;
  logic               w_ei_upd;
  logic               w_take_ime;
  logic               w_dispatch;
  logic               w_fetch;
  logic               w_cb_second;
  logic               w_isr_exit;
  logic               w_halt_enter;
  logic               w_halt_bug_set;
  logic               w_wake;

  gb_cpu_int_prio #(
    .N  (NUM_INT),
    .IW (IW)
  ) u_int_prio (
    .i_req    (int_enable & int_flag),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_vector = VECTOR_BASE + 8'(w_idx) * 8'(VECTOR_STRIDE);

  // Ordering matters: a pending EI lands first, so EI;DI still leaves IME clear.
  always_comb begin
    w_ime_upd = r_ime;
    w_ei_upd  = r_ei_pend;
    if (r_ei_pend) w_ime_upd = 1'b1;
    w_ei_upd = ctl_ei;
    if (ctl_di) begin
      w_ime_upd = 1'b0;
      w_ei_upd  = 1'b0;
    end
    if (ctl_reti) w_ime_upd = 1'b1;
  end

  always_comb begin
    w_take_ime     = 1'b0;
    w_dispatch     = 1'b0;
    w_fetch        = 1'b0;
    w_cb_second    = 1'b0;
    w_isr_exit     = 1'b0;
    w_halt_enter   = 1'b0;
    w_halt_bug_set = 1'b0;
    w_wake         = 1'b0;
    if (m_tick && !reset) begin
      case (r_state)
        ST_RUN: begin
          if (instr_last) begin
            w_take_ime = 1'b1;
            if (w_ime_upd && w_any) begin
              w_dispatch = 1'b1;
            end else if (ctl_halt) begin
              if (w_any && !w_ime_upd) w_halt_bug_set = 1'b1;
              else                     w_halt_enter   = 1'b1;
            end else begin
              w_fetch = 1'b1;
            end
          end
        end
        ST_CB_FETCH: w_cb_second = 1'b1;
        ST_ISR: begin
          if (instr_last) begin
            w_take_ime = 1'b1;
            w_isr_exit = 1'b1;
            w_fetch    = 1'b1;
          end
        end
        ST_HALT: begin
          if (w_any) begin
            w_wake = 1'b1;
            if (r_ime) w_dispatch = 1'b1;
            else       w_fetch    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A HALT-bug fetch latches the byte but leaves PC in place, so it is read again.
  assign pc_inc = (w_fetch & ~r_halt_bug) | w_cb_second;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_opcode     <= OPCODE_NOP;
      r_cb_prefix  <= 1'b0;
      r_isr_cmd    <= 1'b0;
      r_int_ack    <= '0;
      r_isr_vector <= 8'h00;
      r_ime        <= 1'b0;
      r_halted     <= 1'b0;
      r_ei_pend    <= 1'b0;
      r_halt_bug   <= 1'b0;
    end else begin
      r_int_ack <= w_dispatch ? w_onehot : '0;
      if (w_take_ime) begin
        r_ime     <= w_ime_upd;
        r_ei_pend <= w_ei_upd;
      end
      if (w_dispatch) begin
        r_isr_cmd    <= 1'b1;
        r_cb_prefix  <= 1'b0;
        r_opcode     <= OPCODE_NOP;
        r_ime        <= 1'b0;
        r_isr_vector <= w_vector;
        r_state      <= ST_ISR;
      end
      if (w_fetch) begin
        r_opcode    <= fetch_data;
        r_cb_prefix <= 1'b0;
        r_halt_bug  <= 1'b0;
        r_state     <= (fetch_data == OPCODE_CB) ? ST_CB_FETCH : ST_RUN;
      end
      if (w_isr_exit) r_isr_cmd <= 1'b0;
      if (w_cb_second) begin
        r_opcode    <= fetch_data;
        r_cb_prefix <= 1'b1;
        r_state     <= ST_RUN;
      end
      if (w_halt_enter) begin
        r_halted <= 1'b1;
        r_state  <= ST_HALT;
      end
      if (w_halt_bug_set) r_halt_bug <= 1'b1;
      if (w_wake)         r_halted   <= 1'b0;
    end
  end

  assign opcode     = r_opcode;
  assign cb_prefix  = r_cb_prefix;
  assign isr_cmd    = r_isr_cmd;
  assign int_ack    = r_int_ack;
  assign isr_vector = r_isr_vector;
  assign ime        = r_ime;
  assign halted     = r_halted;

endmodule

// File: tb/tb_gb_cpu_fetch_ctrl.sv
// Directed bench for gb_cpu_fetch_ctrl: m_tick every 4 clk, hand-computed expectations.
module tb_gb_cpu_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_tick;
  logic [7:0] fetch_data;
  logic       instr_last;
  logic       ctl_ei;
  logic       ctl_di;
  logic       ctl_reti;
  logic       ctl_halt;
  logic [4:0] int_enable;
  logic [4:0] int_flag;
  logic [7:0] opcode;
  logic       cb_prefix;
  logic       isr_cmd;
  logic       pc_inc;
  logic [4:0] int_ack;
  logic [7:0] isr_vector;
  logic       ime;
  logic       halted;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic t_pc_inc;
  logic [4:0] t_int_ack;

  always #5 clk = ~clk;

  gb_cpu_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .m_tick     (m_tick),
    .fetch_data (fetch_data),
    .instr_last (instr_last),
    .ctl_ei     (ctl_ei),
    .ctl_di     (ctl_di),
    .ctl_reti   (ctl_reti),
    .ctl_halt   (ctl_halt),
    .int_enable (int_enable),
    .int_flag   (int_flag),
    .opcode     (opcode),
    .cb_prefix  (cb_prefix),
    .isr_cmd    (isr_cmd),
    .pc_inc     (pc_inc),
    .int_ack    (int_ack),
    .isr_vector (isr_vector),
    .ime        (ime),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One M-cycle: pc_inc sampled mid-cycle, int_ack right after the edge, then 3 idle clk.
  task automatic do_tick(input logic il, input logic [7:0] d,
                         input logic ei, input logic di, input logic reti, input logic hlt);
    instr_last = il;
    fetch_data = d;
    ctl_ei     = ei;
    ctl_di     = di;
    ctl_reti   = reti;
    ctl_halt   = hlt;
    m_tick     = 1'b1;
    #2;
    t_pc_inc = pc_inc;
    @(posedge clk);
    #1;
    t_int_ack  = int_ack;
    m_tick     = 1'b0;
    instr_last = 1'b0;
    ctl_ei     = 1'b0;
    ctl_di     = 1'b0;
    ctl_reti   = 1'b0;
    ctl_halt   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    m_tick     = 1'b1;
    instr_last = 1'b1;
    fetch_data = 8'hCB;
    ctl_ei     = 1'b0;
    ctl_di     = 1'b0;
    ctl_reti   = 1'b0;
    ctl_halt   = 1'b0;
    int_enable = 5'h00;
    int_flag   = 5'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("pc_inc_in_reset", 32'(pc_inc), 32'd0);
    m_tick     = 1'b0;
    instr_last = 1'b0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_opcode", 32'(opcode), 32'h00);
    chk("rst_cb", 32'(cb_prefix), 32'd0);
    chk("rst_isr", 32'(isr_cmd), 32'd0);
    chk("rst_ime", 32'(ime), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_int_ack", 32'(int_ack), 32'h0);

    // Plain fetch
    do_tick(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f3c_pc_inc", 32'(t_pc_inc), 32'd1);
    chk("f3c_opcode", 32'(opcode), 32'h3C);
    chk("f3c_cb", 32'(cb_prefix), 32'd0);

    // CB prefix then second byte
    do_tick(1'b1, 8'hCB, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cb1_pc_inc", 32'(t_pc_inc), 32'd1);
    do_tick(1'b0, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cb2_pc_inc", 32'(t_pc_inc), 32'd1);
    chk("cb2_opcode", 32'(opcode), 32'h37);
    chk("cb2_cb", 32'(cb_prefix), 32'd1);

    // Tick without instr_last: nothing moves
    do_tick(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nolast_pc_inc", 32'(t_pc_inc), 32'd0);
    chk("nolast_opcode", 32'(opcode), 32'h37);
    chk("nolast_cb", 32'(cb_prefix), 32'd1);

    // EI delay: pending IE&IF=5'h14 dispatches only one instruction later
    int_enable = 5'h1F;
    int_flag   = 5'h14;
    do_tick(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ei_no_disp_isr", 32'(isr_cmd), 32'd0);
    chk("ei_no_disp_ime", 32'(ime), 32'd0);
    chk("ei_opcode", 32'(opcode), 32'h41);
    chk("ei_pc_inc", 32'(t_pc_inc), 32'd1);
    do_tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_isr", 32'(isr_cmd), 32'd1);
    chk("disp_ack", 32'(t_int_ack), 32'h04);
    chk("disp_vec", 32'(isr_vector), 32'h50);
    chk("disp_ime", 32'(ime), 32'd0);
    chk("disp_pc_inc", 32'(t_pc_inc), 32'd0);
    chk("disp_opcode", 32'(opcode), 32'h00);
    chk("disp_ack_pulse", 32'(int_ack), 32'h0);

    // ISR holds, then exits with a fetch at the vector
    do_tick(1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("isr_hold", 32'(isr_cmd), 32'd1);
    do_tick(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("isr_exit", 32'(isr_cmd), 32'd0);
    chk("isr_exit_opcode", 32'(opcode), 32'hC3);
    chk("isr_exit_pc_inc", 32'(t_pc_inc), 32'd1);

    // HALT bug: ime=0 with IE&IF pending
    do_tick(1'b1, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hbug_halted", 32'(halted), 32'd0);
    chk("hbug_tick_pc_inc", 32'(t_pc_inc), 32'd0);
    do_tick(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hbug_fetch_pc_inc", 32'(t_pc_inc), 32'd0);
    chk("hbug_fetch_opcode", 32'(opcode), 32'h12);
    do_tick(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hbug_after_pc_inc", 32'(t_pc_inc), 32'd1);
    chk("hbug_after_opcode", 32'(opcode), 32'h13);

    // RETI sets ime; DI alongside a pending interrupt blocks dispatch
    int_flag = 5'h00;
    do_tick(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reti_ime", 32'(ime), 32'd1);
    int_flag = 5'h01;
    do_tick(1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("di_ime", 32'(ime), 32'd0);
    chk("di_no_disp", 32'(isr_cmd), 32'd0);
    chk("di_opcode", 32'(opcode), 32'h21);

    // HALT with ime=1, then wake into dispatch
    int_flag = 5'h00;
    do_tick(1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc_inc", 32'(t_pc_inc), 32'd0);
    chk("halt_opcode", 32'(opcode), 32'h30);
    do_tick(1'b0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_stay_pc_inc", 32'(t_pc_inc), 32'd0);
    int_flag = 5'h01;
    do_tick(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wake_halted", 32'(halted), 32'd0);
    chk("wake_isr", 32'(isr_cmd), 32'd1);
    chk("wake_ack", 32'(t_int_ack), 32'h01);
    chk("wake_vec", 32'(isr_vector), 32'h40);
    chk("wake_ime", 32'(ime), 32'd0);
    chk("wake_pc_inc", 32'(t_pc_inc), 32'd0);

    // Reset in the middle of the ISR schedule
    reset      = 1'b1;
    m_tick     = 1'b1;
    instr_last = 1'b1;
    fetch_data = 8'h55;
    #2;
    chk("midisr_rst_pc_inc", 32'(pc_inc), 32'd0);
    @(posedge clk);
    #1;
    m_tick     = 1'b0;
    instr_last = 1'b0;
    reset      = 1'b0;
    chk("midisr_isr", 32'(isr_cmd), 32'd0);
    chk("midisr_vec", 32'(isr_vector), 32'h00);
    chk("midisr_opcode", 32'(opcode), 32'h00);
    chk("midisr_ime", 32'(ime), 32'd0);
    chk("midisr_halted", 32'(halted), 32'd0);
    chk("midisr_cb", 32'(cb_prefix), 32'd0);
    chk("midisr_ack", 32'(int_ack), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    do_tick(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_pc_inc", 32'(t_pc_inc), 32'd1);
    chk("post_rst_opcode", 32'(opcode), 32'h66);
    chk("post_rst_isr", 32'(isr_cmd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
